// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle from the sync generator to the character memory stage.
interface vga_sync_gen_if;
  logic        xsync;
  logic        ysync;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        valid;
  logic        pix_tick;
  logic        frame_start;
  logic        blink;

  modport master (
    output xsync, ysync, xpos, ypos, valid, pix_tick, frame_start, blink
  );

  modport slave (
    input xsync, ysync, xpos, ypos, valid, pix_tick, frame_start, blink
  );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel-tick divider, h/v counters, registered syncs,
// pixel position, visible flag, frame strobe and blink phase.
module vga_sync_gen #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned H_FP         = 16,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_BP         = 48,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned V_FP         = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_BP         = 33,
  parameter int unsigned SYNC_POL     = 0,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic           clk,
  input  logic           clr,
  vga_sync_gen_if.master vga
);
  localparam int unsigned CW      = 12;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned FC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic        SYNC_ACT = 1'(SYNC_POL);

  logic [DIV_W-1:0] div;
  logic [CW-1:0]    hcnt;
  logic [CW-1:0]    vcnt;
  logic [FC_W-1:0]  fcnt;

  logic tick;
  logic h_sync_win;
  logic v_sync_win;
  logic visible;
  logic at_origin;
  logic h_last;
  logic v_last;

  // Decode of the current counter position; loaded into the outputs on a tick.
  always_comb begin
    tick       = (div == DIV_W'(CLK_DIV - 1));
    h_sync_win = (hcnt >= CW'(H_ACTIVE + H_FP)) && (hcnt < CW'(H_ACTIVE + H_FP + H_SYNC));
    v_sync_win = (vcnt >= CW'(V_ACTIVE + V_FP)) && (vcnt < CW'(V_ACTIVE + V_FP + V_SYNC));
    visible    = (hcnt < CW'(H_ACTIVE)) && (vcnt < CW'(V_ACTIVE));
    at_origin  = (hcnt == '0) && (vcnt == '0);
    h_last     = (hcnt == CW'(H_TOTAL - 1));
    v_last     = (vcnt == CW'(V_TOTAL - 1));
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      div             <= '0;
      hcnt            <= '0;
      vcnt            <= '0;
      fcnt            <= '0;
      vga.xsync       <= ~SYNC_ACT;
      vga.ysync       <= ~SYNC_ACT;
      vga.xpos        <= '0;
      vga.ypos        <= '0;
      vga.valid       <= 1'b0;
      vga.pix_tick    <= 1'b0;
      vga.frame_start <= 1'b0;
      vga.blink       <= 1'b0;
    end else begin
      vga.pix_tick <= tick;
      div          <= tick ? '0 : DIV_W'(div + 1'b1);

      if (tick) begin
        vga.xpos        <= hcnt;
        vga.ypos        <= vcnt;
        vga.valid       <= visible;
        vga.xsync       <= h_sync_win ? SYNC_ACT : ~SYNC_ACT;
        vga.ysync       <= v_sync_win ? SYNC_ACT : ~SYNC_ACT;
        vga.frame_start <= at_origin;

        if (h_last) begin
          hcnt <= '0;
          vcnt <= v_last ? '0 : CW'(vcnt + 1'b1);
        end else begin
          hcnt <= CW'(hcnt + 1'b1);
        end

        // Blink phase advances once per frame, on the tick that emits the origin.
        if (at_origin) begin
          if (fcnt == FC_W'(BLINK_FRAMES - 1)) begin
            fcnt      <= '0;
            vga.blink <= ~vga.blink;
          end else begin
            fcnt <= FC_W'(fcnt + 1'b1);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default 640x480 timing at CLK_DIV=4, plus a short-frame
// CLK_DIV=1 active-high instance for frame, blink and mid-frame reset behaviour.
module tb_vga_sync_gen;
  logic clk = 1'b0;
  logic clr_a;
  logic clr_b;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic blink_seen [0:3];

  vga_sync_gen_if ifa ();
  vga_sync_gen_if ifb ();

  vga_sync_gen #(.CLK_DIV(4)) u_a (
    .clk (clk),
    .clr (clr_a),
    .vga (ifa)
  );

  vga_sync_gen #(
    .CLK_DIV(1), .SYNC_POL(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .BLINK_FRAMES(2)
  ) u_b (
    .clk (clk),
    .clr (clr_b),
    .vga (ifb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int first_inv, sync_first, sync_last, sync_cnt, seq_err, hold_err, prev_x, vcnt_a;
    int run, maxrun, nt_err, fs_cnt, ys_cnt, ys_min, ys_max, vinv, vis_cnt, last_fs, gap_err;
    int found;

    clr_a = 1'b1;
    clr_b = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_xsync",  int'(ifa.xsync), 1);
    chk("rst_ysync",  int'(ifa.ysync), 1);
    chk("rst_xpos",   int'(ifa.xpos), 0);
    chk("rst_ypos",   int'(ifa.ypos), 0);
    chk("rst_valid",  int'(ifa.valid), 0);
    chk("rst_tick",   int'(ifa.pix_tick), 0);
    chk("rst_fstart", int'(ifa.frame_start), 0);
    chk("rst_blink",  int'(ifa.blink), 0);
    chk("rst_b_xsync", int'(ifb.xsync), 0);
    chk("rst_b_ysync", int'(ifb.ysync), 0);

    // First tick four clocks after release
    clr_a = 1'b0;
    repeat (3) @(negedge clk);
    chk("a_no_tick_yet", int'(ifa.pix_tick), 0);
    @(negedge clk);
    chk("a_first_tick",   int'(ifa.pix_tick), 1);
    chk("a_first_xpos",   int'(ifa.xpos), 0);
    chk("a_first_ypos",   int'(ifa.ypos), 0);
    chk("a_first_valid",  int'(ifa.valid), 1);
    chk("a_first_fstart", int'(ifa.frame_start), 1);
    chk("a_first_xsync",  int'(ifa.xsync), 1);

    // One full line plus the wrap
    prev_x = int'(ifa.xpos);
    first_inv = -1; sync_first = -1; sync_last = -1;
    sync_cnt = 0; seq_err = 0; hold_err = 0; vcnt_a = 0;
    for (int k = 1; k <= 800; k++) begin
      for (int j = 1; j <= 4; j++) begin
        @(negedge clk);
        if (j < 4 && (ifa.pix_tick !== 1'b0 || int'(ifa.xpos) != prev_x)) hold_err++;
      end
      if (ifa.pix_tick !== 1'b1) seq_err++;
      if (int'(ifa.xpos) != k % 800 || int'(ifa.ypos) != k / 800) seq_err++;
      if (ifa.valid === 1'b1) vcnt_a++;
      if (ifa.valid === 1'b0 && first_inv < 0) first_inv = int'(ifa.xpos);
      if (ifa.xsync === 1'b0) begin
        sync_cnt++;
        if (sync_first < 0) sync_first = int'(ifa.xpos);
        sync_last = int'(ifa.xpos);
      end
      prev_x = int'(ifa.xpos);
    end
    chk("a_hold_between_ticks", hold_err, 0);
    chk("a_pos_sequence",       seq_err, 0);
    chk("a_valid_falls_at",     first_inv, 640);
    chk("a_valid_count",        vcnt_a, 640);
    chk("a_hsync_first",        sync_first, 656);
    chk("a_hsync_last",         sync_last, 751);
    chk("a_hsync_width",        sync_cnt, 96);
    chk("a_wrap_xpos",          int'(ifa.xpos), 0);
    chk("a_wrap_ypos",          int'(ifa.ypos), 1);

    // Short-frame instance: tick every clock, active-high syncs
    clr_b = 1'b0;
    @(negedge clk);
    chk("b_first_tick",   int'(ifb.pix_tick), 1);
    chk("b_first_fstart", int'(ifb.frame_start), 1);
    chk("b_first_xsync",  int'(ifb.xsync), 0);
    chk("b_first_valid",  int'(ifb.valid), 1);

    run = 0; maxrun = 0; nt_err = 0; fs_cnt = 0; ys_cnt = 0;
    ys_min = 999; ys_max = -1; vinv = 0; vis_cnt = 0; last_fs = -1; gap_err = 0;
    for (int c = 0; c < 25600; c++) begin
      if (c > 0) @(negedge clk);
      if (ifb.pix_tick !== 1'b1) nt_err++;
      if (ifb.xsync === 1'b1) begin
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
      if (ifb.ysync === 1'b1) begin
        ys_cnt++;
        if (int'(ifb.ypos) < ys_min) ys_min = int'(ifb.ypos);
        if (int'(ifb.ypos) > ys_max) ys_max = int'(ifb.ypos);
      end
      if (ifb.valid === 1'b1) begin
        vis_cnt++;
        if (ifb.ypos >= 12'd4) vinv++;
      end
      if (ifb.frame_start === 1'b1) begin
        if (fs_cnt < 4) blink_seen[fs_cnt] = ifb.blink;
        if (last_fs >= 0 && c - last_fs != 6400) gap_err++;
        last_fs = c;
        fs_cnt++;
      end
    end
    chk("b_tick_every_clk",   nt_err, 0);
    chk("b_hsync_run",        maxrun, 96);
    chk("b_vsync_samples",    ys_cnt, 6400);
    chk("b_vsync_ymin",       ys_min, 5);
    chk("b_vsync_ymax",       ys_max, 6);
    chk("b_valid_blank_rows", vinv, 0);
    chk("b_valid_count",      vis_cnt, 10240);
    chk("b_fstart_count",     fs_cnt, 4);
    chk("b_fstart_spacing",   gap_err, 0);
    chk("b_blink_f1", int'(blink_seen[0]), 0);
    chk("b_blink_f2", int'(blink_seen[1]), 1);
    chk("b_blink_f3", int'(blink_seen[2]), 1);
    chk("b_blink_f4", int'(blink_seen[3]), 0);

    // Reset inside both sync pulses with blink set
    found = 0;
    for (int c = 0; c < 20000 && found == 0; c++) begin
      @(negedge clk);
      if (ifb.xpos == 12'd700 && ifb.ypos == 12'd5 && ifb.blink === 1'b1) found = 1;
    end
    chk("b_reach_700_5",   found, 1);
    chk("b_pre_clr_xsync", int'(ifb.xsync), 1);
    chk("b_pre_clr_ysync", int'(ifb.ysync), 1);
    clr_b = 1'b1;
    #1;
    chk("b_clr_xsync", int'(ifb.xsync), 0);
    chk("b_clr_ysync", int'(ifb.ysync), 0);
    chk("b_clr_xpos",  int'(ifb.xpos), 0);
    chk("b_clr_ypos",  int'(ifb.ypos), 0);
    chk("b_clr_valid", int'(ifb.valid), 0);
    chk("b_clr_tick",  int'(ifb.pix_tick), 0);
    chk("b_clr_blink", int'(ifb.blink), 0);
    repeat (2) @(negedge clk);
    chk("b_clr_hold_xsync", int'(ifb.xsync), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
